// File: rtl/simple_mem_responder_if.sv
// Request/response handshake bundle between a bus requester and simple_mem_responder.
// The requester drives the master side; the responder sits on the slave side.
interface simple_mem_responder_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/simple_mem_responder.sv
// Single-request memory responder: accepts one access, waits LATENCY cycles, commits, then
// holds the response until it is taken. A sideband preload port writes the array while idle.
//
// state | meaning
// IDLE  | ready for a request or a preload write
// WAIT  | request latched, counting down the programmed latency
// RESP  | access committed, response held until resp_ready
module simple_mem_responder #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  simple_mem_responder_if.slave bus,
  input  logic                  init_we,
  input  logic [ADDR_W-1:0]     init_addr,
  input  logic [DATA_W-1:0]     init_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0]  LAT     = 4'(LATENCY);
  localparam int unsigned DEPTH_U = DEPTH;
  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              hs;
  logic              commit;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_ok;
  logic              init_ok;
  logic [IDX_W-1:0]  acc_idx;
  logic [IDX_W-1:0]  init_idx;

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    hs            = 1'b0;
    commit        = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = !init_we && !reset;
        hs            = bus.req_valid && !init_we && !reset;
        if (hs) begin
          state_nxt = (LAT != 4'd0) ? WAIT : RESP;
          commit    = (LAT == 4'd0);
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_valid && bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With zero latency the access commits straight from the live request fields.
  assign acc_we    = (state == IDLE) ? bus.req_we    : lat_we;
  assign acc_addr  = (state == IDLE) ? bus.req_addr  : lat_addr;
  assign acc_wdata = (state == IDLE) ? bus.req_wdata : lat_wdata;
  assign acc_ok    = 32'(acc_addr) < DEPTH_U;
  assign init_ok   = 32'(init_addr) < DEPTH_U;
  assign acc_idx   = acc_addr[IDX_W-1:0];
  assign init_idx  = init_addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      lat_we         <= 1'b0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        cnt       <= LAT;
        lat_we    <= bus.req_we;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state == IDLE && init_we && init_ok) mem[init_idx] <= init_data;
      if (commit) begin
        bus.resp_valid <= 1'b1;
        if (!acc_ok) begin
          bus.resp_rdata <= '0;
          bus.resp_err   <= 1'b1;
        end else if (acc_we) begin
          mem[acc_idx]   <= acc_wdata;
          bus.resp_rdata <= '0;
        end else begin
          bus.resp_rdata <= mem[acc_idx];
        end
      end else if (state == RESP && bus.resp_ready) begin
        bus.resp_valid <= 1'b0;
        bus.resp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_simple_mem_responder.sv
// Bench for simple_mem_responder: three builds (D16/L1, D12/L0, D16/L3) checked every cycle
// against a transaction-level model, plus directed literal expectations and random traffic.
module tb_simple_mem_responder;
  localparam int NCH = 3;
  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int DEP [NCH] = '{16, 12, 16};
  localparam int LAT [NCH] = '{1, 0, 3};

  logic clk = 1'b0;
  logic [NCH-1:0]         rst;
  logic [NCH-1:0]         req_valid, req_we, resp_ready, init_we;
  logic [NCH-1:0][AW-1:0] req_addr, init_addr;
  logic [NCH-1:0][DW-1:0] req_wdata, init_data;
  logic [NCH-1:0]         req_ready, resp_valid, resp_err;
  logic [NCH-1:0][DW-1:0] resp_rdata;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCH; g++) begin : gen_ch
    simple_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    assign bus.req_valid  = req_valid[g];
    assign bus.req_we     = req_we[g];
    assign bus.req_addr   = req_addr[g];
    assign bus.req_wdata  = req_wdata[g];
    assign bus.resp_ready = resp_ready[g];
    assign req_ready[g]   = bus.req_ready;
    assign resp_valid[g]  = bus.resp_valid;
    assign resp_rdata[g]  = bus.resp_rdata;
    assign resp_err[g]    = bus.resp_err;

    simple_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP[g]), .LATENCY(LAT[g])) dut (
      .clk       (clk),
      .reset     (rst[g]),
      .bus       (bus.slave),
      .init_we   (init_we[g]),
      .init_addr (init_addr[g]),
      .init_data (init_data[g])
    );
  end

  function automatic void chk(input string name, input int c, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s ch%0d actual=%0h required=%0h t=%0t", name, c, act, exp, $time);
    end
  endfunction

  // Transaction-level model: a busy flag with a cycles-left count, and the response value
  // computed from the model array at the moment the access is due.
  logic [DW-1:0] m_mem [NCH][16];
  bit            m_busy  [NCH];
  bit            m_valid [NCH];
  bit            m_err   [NCH];
  logic [DW-1:0] m_rdata [NCH];
  int            m_left  [NCH];
  bit            o_we    [NCH];
  int            o_addr  [NCH];
  logic [DW-1:0] o_wd    [NCH];

  function automatic void m_commit(input int c);
    m_valid[c] = 1'b1;
    if (o_addr[c] >= DEP[c]) begin
      m_err[c]   = 1'b1;
      m_rdata[c] = '0;
    end else if (o_we[c]) begin
      m_mem[c][o_addr[c]] = o_wd[c];
      m_rdata[c] = '0;
    end else begin
      m_rdata[c] = m_mem[c][o_addr[c]];
    end
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (rst[c]) begin
        for (int a = 0; a < 16; a++) m_mem[c][a] = '0;
        m_busy[c]  = 1'b0;
        m_valid[c] = 1'b0;
        m_err[c]   = 1'b0;
        m_rdata[c] = '0;
      end else if (!m_busy[c] && !m_valid[c]) begin
        if (init_we[c]) begin
          if (int'(init_addr[c]) < DEP[c]) m_mem[c][init_addr[c]] = init_data[c];
        end else if (req_valid[c]) begin
          o_we[c]   = req_we[c];
          o_addr[c] = int'(req_addr[c]);
          o_wd[c]   = req_wdata[c];
          m_left[c] = LAT[c];
          if (m_left[c] == 0) m_commit(c);
          else m_busy[c] = 1'b1;
        end
      end else if (m_busy[c]) begin
        m_left[c]--;
        if (m_left[c] == 0) begin
          m_busy[c] = 1'b0;
          m_commit(c);
        end
      end else if (resp_ready[c]) begin
        m_valid[c] = 1'b0;
        m_err[c]   = 1'b0;
      end
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (started) begin
      for (int c = 0; c < NCH; c++) begin
        chk("req_ready", c, req_ready[c], !rst[c] && !m_busy[c] && !m_valid[c] && !init_we[c]);
        chk("resp_valid", c, resp_valid[c], m_valid[c]);
        chk("resp_err", c, resp_err[c], m_err[c]);
        if (m_valid[c]) chk("resp_rdata", c, resp_rdata[c], m_rdata[c]);
      end
    end
  end

  task automatic preload(input int c, input int a, input logic [DW-1:0] d);
    init_we[c] = 1'b1;
    init_addr[c] = a[AW-1:0];
    init_data[c] = d;
    @(negedge clk);
    init_we[c] = 1'b0;
  endtask

  // Returns at the negedge following the handshake edge; waits = cycles spent not ready.
  task automatic send(input int c, input bit we, input int a, input logic [DW-1:0] d,
                      output int waits);
    bit ok = 1'b0;
    req_valid[c] = 1'b1;
    req_we[c]    = we;
    req_addr[c]  = a[AW-1:0];
    req_wdata[c] = d;
    waits = 0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (req_ready[c]) begin
        ok = 1'b1;
        break;
      end
      waits++;
      @(negedge clk);
    end
    if (!ok) chk("send_timeout", c, 0, 1);
    @(negedge clk);
    req_valid[c] = 1'b0;
  endtask

  task automatic recv(input int c, input int hold, output int lat, output logic [DW-1:0] rd,
                      output logic er);
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (resp_valid[c]) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) chk("recv_timeout", c, 0, 1);
    rd = resp_rdata[c];
    er = resp_err[c];
    repeat (hold) @(negedge clk);
    resp_ready[c] = 1'b1;
    @(negedge clk);
    resp_ready[c] = 1'b0;
  endtask

  task automatic access(input int c, input bit we, input int a, input logic [DW-1:0] d,
                        input int hold, output int lat, output logic [DW-1:0] rd,
                        output logic er);
    int w;
    send(c, we, a, d, w);
    recv(c, hold, lat, rd, er);
  endtask

  initial begin
    int lat, w;
    logic [DW-1:0] rd;
    logic er;
    rst = '1;
    req_valid = '0; req_we = '0; resp_ready = '0; init_we = '0;
    req_addr = '0; init_addr = '0; req_wdata = '0; init_data = '0;
    started = 1'b1;
    repeat (2) @(negedge clk);
    rst = '0;
    #1;
    for (int c = 0; c < NCH; c++) begin
      chk("reset_resp_valid", c, resp_valid[c], 0);
      chk("reset_resp_rdata", c, resp_rdata[c], 0);
      chk("reset_resp_err", c, resp_err[c], 0);
    end
    @(negedge clk);

    // preload then read, latency one
    preload(0, 3, 8'h5A);
    access(0, 1'b0, 3, 8'h00, 0, lat, rd, er);
    chk("t1_latency", 0, lat, 1);
    chk("t1_rdata", 0, rd, 8'h5A);
    chk("t1_err", 0, er, 0);

    // write then read back
    access(0, 1'b1, 7, 8'hC3, 0, lat, rd, er);
    chk("t2_wr_rdata", 0, rd, 8'h00);
    access(0, 1'b0, 7, 8'h00, 1, lat, rd, er);
    chk("t2_rd_rdata", 0, rd, 8'hC3);

    // backpressure with a competing request held on the bus
    send(0, 1'b0, 3, 8'h00, w);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 4'd9; req_wdata[0] = 8'h11;
    recv(0, 5, lat, rd, er);
    req_valid[0] = 1'b0;
    chk("t3_rdata", 0, rd, 8'h5A);
    access(0, 1'b0, 9, 8'h00, 0, lat, rd, er);
    chk("t3_no_write", 0, rd, 8'h00);

    // preload has priority over a simultaneous request
    init_we[0] = 1'b1; init_addr[0] = 4'd4; init_data[0] = 8'h66;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 4'd4;
    #1;
    chk("t5_ready_blocked", 0, req_ready[0], 0);
    @(negedge clk);
    init_we[0] = 1'b0;
    send(0, 1'b0, 4, 8'h00, w);
    chk("t5_next_cycle_accept", 0, w, 0);
    recv(0, 0, lat, rd, er);
    chk("t5_rdata", 0, rd, 8'h66);

    // out-of-range accesses on the 12-word build
    for (int a = 0; a < 16; a++) preload(1, a, 8'(a + 1));
    access(1, 1'b0, 13, 8'h00, 0, lat, rd, er);
    chk("t4_rd_err", 1, er, 1);
    chk("t4_rd_rdata", 1, rd, 0);
    chk("t4_latency", 1, lat, 0);
    access(1, 1'b1, 14, 8'hFF, 2, lat, rd, er);
    chk("t4_wr_err", 1, er, 1);
    chk("t4_wr_rdata", 1, rd, 0);
    for (int a = 0; a < 12; a++) access(1, 1'b0, a, 8'h00, 0, lat, rd, er);
    access(1, 1'b0, 6, 8'h00, 0, lat, rd, er);
    chk("t4_sweep_6", 1, rd, 8'h07);

    // latency three; preload during WAIT is ignored
    send(2, 1'b0, 5, 8'h00, w);
    init_we[2] = 1'b1; init_addr[2] = 4'd5; init_data[2] = 8'h77;
    @(negedge clk);
    init_we[2] = 1'b0;
    recv(2, 0, lat, rd, er);
    chk("t5_wait_rdata", 2, rd, 8'h00);
    access(2, 1'b0, 5, 8'h00, 0, lat, rd, er);
    chk("t5_wait_ignored", 2, rd, 8'h00);
    chk("t6_latency", 2, lat, 3);

    // reset during WAIT discards the pending write
    send(2, 1'b1, 2, 8'hAB, w);
    rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    #1;
    chk("t6_valid_after_reset", 2, resp_valid[2], 0);
    @(negedge clk);
    access(2, 1'b0, 2, 8'h00, 0, lat, rd, er);
    chk("t6_mem2", 2, rd, 8'h00);

    // random traffic on every build
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(0, 5) == 0) begin
          preload(c, int'($urandom_range(0, 15)), 8'($urandom));
        end else begin
          access(c, 1'($urandom), int'($urandom_range(0, 15)), 8'($urandom),
                 int'($urandom_range(0, 3)), lat, rd, er);
          chk("rand_latency", c, lat, LAT[c]);
        end
      end
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
